// File: rtl/fifo_pack.sv
// Packs IN_W-bit beats into RATIO-lane words for a downstream FIFO write port.
// A closed word sits in a one-deep output register until the FIFO has room.
module fifo_pack #(
  parameter  int IN_W  = 8,
  parameter  int RATIO = 4,
  localparam int OUT_W = IN_W * RATIO,
  localparam int CNT_W = $clog2(RATIO) + 1
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             in_valid_i,
  input  logic [IN_W-1:0]  in_data_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  input  logic             full_i,
  output logic             wr_o,
  output logic [OUT_W-1:0] wr_data_o,
  output logic [CNT_W-1:0] wr_cnt_o,
  output logic             wr_last_o
);

  logic [RATIO-1:0][IN_W-1:0] acc_q, acc_d;
  logic [RATIO-1:0][IN_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [CNT_W-1:0]           out_cnt_q, out_cnt_d;
  logic                       out_vld_q, out_vld_d;
  logic                       out_last_q, out_last_d;
  logic                       accept;
  logic                       closing;
  int unsigned                cnt_u;

  assign in_ready_o = !out_vld_q || !full_i;
  assign wr_o       = out_vld_q && !full_i;
  assign wr_data_o  = out_data_q;
  assign wr_cnt_o   = out_cnt_q;
  assign wr_last_o  = out_last_q;

  assign accept  = in_valid_i && in_ready_o;
  assign closing = accept && ((cnt_q == CNT_W'(RATIO - 1)) || in_last_i);
  assign cnt_u   = 32'(cnt_q);

  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;

    if (wr_o) out_vld_d = 1'b0;

    // A closing beat overrides the write-clear so the register reloads in place.
    if (closing) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (k < cnt_u)       out_data_d[k] = acc_q[k];
        else if (k == cnt_u) out_data_d[k] = in_data_i;
        else                 out_data_d[k] = '0;
      end
      out_cnt_d  = cnt_q + CNT_W'(1);
      out_last_d = in_last_i;
      out_vld_d  = 1'b1;
      acc_d      = '0;
      cnt_d      = '0;
    end else if (accept) begin
      for (int unsigned k = 0; k < RATIO; k++) begin
        if (k == cnt_u) acc_d[k] = in_data_i;
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: doc/fifo_pack.md
FIFO_PACK -- requirements
Module: fifo_pack

Interface
REQ-001 Parameter IN_W, default 8: width of one input beat in bits.
REQ-002 Parameter RATIO, default 4: input beats per packed word; power of two, at least 2.
REQ-003 Derived OUT_W = IN_W*RATIO; CNT_W = $clog2(RATIO)+1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 nreset  input  1  asynchronous active-low reset.
REQ-006 in_valid_i  input  1  input beat valid.
REQ-007 in_data_i  input  IN_W  input beat data.
REQ-008 in_last_i  input  1  beat closes the current word (may leave the word partial).
REQ-009 in_ready_o  output  1  block accepts the beat this cycle.
REQ-010 full_i  input  1  downstream FIFO full flag.
REQ-011 wr_o  output  1  write strobe to the downstream FIFO (valid).
REQ-012 wr_data_o  output  OUT_W  packed word.
REQ-013 wr_cnt_o  output  CNT_W  number of valid lanes in wr_data_o (1..RATIO).
REQ-014 wr_last_o  output  1  the word was closed by in_last_i.

Function
REQ-015 A beat is accepted when in_valid_i && in_ready_o are high at a rising edge; no other beat shall change state.
REQ-016 Lane k is bits [k*IN_W +: IN_W]; the first accepted beat of a word goes to lane 0, the next to lane 1, and so on.
REQ-017 Accumulator counter cnt, range 0..RATIO-1, counts beats already held for the current word.
REQ-018 On an accepted beat with cnt < RATIO-1 and in_last_i low: store the beat in lane cnt and increment cnt.
REQ-019 On an accepted beat with cnt == RATIO-1 or in_last_i high, the block shall close the word:
- Load the output register with the held lanes plus this beat.
- Load wr_cnt_o with cnt+1 and wr_last_o with in_last_i.
- Set out_vld and clear cnt to 0.
REQ-020 Lanes at or above wr_cnt_o shall be driven to zero in wr_data_o; the accumulator shall clear its lanes when a word closes.
REQ-021 wr_o = out_vld && !full_i, combinational.
REQ-022 out_vld clears on the edge where wr_o is high, unless a new word closes on the same edge; in that case the output register reloads and out_vld stays high.
REQ-023 in_ready_o = !out_vld || !full_i, combinational; a held word is never overwritten before it is written.
REQ-024 Latency is one cycle: the word appears on wr_o the cycle after its closing beat, provided full_i is low.
REQ-025 Full throughput: with full_i held low, one beat is accepted every cycle and one word is written every RATIO cycles.
REQ-026 While full_i is high and out_vld is set:
- in_ready_o is low and no beats are accepted.
- wr_data_o, wr_cnt_o and wr_last_o are held stable.
REQ-027 in_last_i on the first beat of a word produces a single-lane word with wr_cnt_o = 1.
REQ-028 If in_valid_i is low, cnt and the partial word are retained indefinitely; there is no timeout flush.
REQ-029 full_i deasserting while out_vld is set makes wr_o high that cycle; a beat can be accepted on the same edge.

Reset
REQ-030 When nreset is low:
- cnt = 0, out_vld = 0 and the accumulator is zeroed immediately.
- Outputs: wr_o = 0, wr_data_o = 0, wr_cnt_o = 0, wr_last_o = 0, in_ready_o = 1.
REQ-031 Reset mid-word discards partial lanes and any held output word; after release, the first accepted beat lands in lane 0.

Verification (IN_W=8, RATIO=4)
REQ-032 Full word: beats 0x11, 0x22, 0x33, 0x44 on consecutive cycles, full_i = 0 -> one cycle after the 4th beat: wr_o = 1, wr_data_o = 0x44332211, wr_cnt_o = 4, wr_last_o = 0.
REQ-033 Partial word: beats 0xAA, 0xBB with in_last_i on 0xBB -> wr_data_o = 0x0000BBAA, wr_cnt_o = 2, wr_last_o = 1; the next word starts in lane 0.
REQ-034 Backpressure:
- full_i = 1 while a word is held -> in_ready_o = 0 and output stable for 5 cycles.
- full_i drops -> wr_o = 1 for exactly one cycle, and a beat is accepted on the same edge.
REQ-035 Streaming: 16 continuous beats 0x00..0x0F, full_i = 0 -> 4 writes, 0x03020100 .. 0x0F0E0D0C, no stalls, in_ready_o constantly 1.
REQ-036 Reset mid-word: 2 beats accepted, nreset pulsed low -> all outputs zero immediately; then beats 0x01..0x04 -> wr_data_o = 0x04030201.
REQ-037 Single-lane word: one beat 0x5A with in_last_i -> wr_data_o = 0x0000005A, wr_cnt_o = 1, wr_last_o = 1.
